// File: rtl/lzs_decode_core.sv
// LZS decompression core: token and length decoder feeding a copy engine that
// reads back through an external 1-cycle-latency history RAM.
//
// state   | meaning
// S_IDLE  | waiting for ce
// S_TOKEN | decoding a literal, offset or end marker
// S_LEN1  | first 2-bit length code
// S_LEN2  | second 2-bit length code
// S_LENX  | 4-bit length extension nibbles
// S_RD    | history read address presented
// S_EMIT  | history byte presented downstream
// S_END   | end marker or input exhausted, sticky
// S_ERR   | decode error, sticky
module lzs_decode_core #(
    parameter int HIST_AW = 11,
    parameter int CNT_W   = 32,
    parameter int CHK_OFF = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    input  logic [12:0]        stream_data,
    input  logic               stream_valid,
    input  logic               stream_done,
    output logic [3:0]         stream_width,
    output logic               stream_ack,
    output logic [7:0]         out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_done,
    output logic               err,
    output logic [CNT_W-1:0]   byte_cnt,
    output logic [HIST_AW-1:0] hwaddr,
    output logic               hwe,
    output logic [7:0]         hdata_o,
    output logic [HIST_AW-1:0] hraddr,
    input  logic [7:0]         hdata
);

    typedef enum logic [3:0] {
        S_IDLE, S_TOKEN, S_LEN1, S_LEN2, S_LENX, S_RD, S_EMIT, S_END, S_ERR
    } state_t;

    state_t             state_q, state_d, rd_state;
    logic [HIST_AW-1:0] waddr_q, waddr_d, raddr_q, raddr_d, rd_addr;
    logic [15:0]        len_q, len_d;
    logic [16:0]        len_sum;
    logic [10:0]        offset_q, offset_d;
    logic               wrapped_q, wrapped_d;
    logic               out_valid_q, out_valid_d;
    logic [7:0]         out_data_q, out_data_d;
    logic               out_done_q, out_done_d, err_q, err_d;
    logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic               accept, stall, dec_ok, eos, off_bad;

    assign accept  = out_valid_q & out_ready;
    assign stall   = out_valid_q & ~out_ready;
    assign dec_ok  = stream_valid & ~stall;
    assign eos     = ~stream_valid & stream_done;

    // Copy source is based on the write pointer after any write landing this
    // cycle, so a byte accepted alongside the length code is already counted.
    assign waddr_d   = accept ? waddr_q + 1'b1 : waddr_q;
    assign wrapped_d = wrapped_q | (accept & (&waddr_q));
    assign rd_addr   = waddr_d - HIST_AW'(offset_q);
    assign off_bad   = (CHK_OFF != 0) && !wrapped_d && (HIST_AW'(offset_q) > waddr_d);
    assign rd_state  = off_bad ? S_ERR : S_RD;
    assign len_sum   = {1'b0, len_q} + {13'd0, stream_data[12:9]};

    assign out_data  = (state_q == S_EMIT) ? hdata : out_data_q;
    assign out_valid = out_valid_q;
    assign out_done  = out_done_q;
    assign err       = err_q;
    assign byte_cnt  = byte_cnt_q;
    assign hwe       = accept;
    assign hwaddr    = waddr_q;
    assign hdata_o   = out_data;
    assign hraddr    = raddr_q;
    assign out_done_d = (state_d == S_END);
    assign err_d      = (state_d == S_ERR);

    always_comb begin
        state_d      = state_q;
        raddr_d      = raddr_q;
        len_d        = len_q;
        offset_d     = offset_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        byte_cnt_d   = byte_cnt_q;
        stream_ack   = 1'b0;
        stream_width = 4'd0;

        if (accept) begin
            out_valid_d = 1'b0;
            out_data_d  = out_data;
            if (!(&byte_cnt_q)) byte_cnt_d = byte_cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: if (ce) state_d = S_TOKEN;
            S_TOKEN: begin
                if (dec_ok) begin
                    stream_ack   = 1'b1;
                    stream_width = 4'd9;
                    if (!stream_data[12]) begin
                        out_data_d  = stream_data[11:4];
                        out_valid_d = 1'b1;
                    end else if (stream_data[12:4] == 9'b110000000) begin
                        state_d = S_END;
                    end else if (stream_data[11]) begin
                        offset_d = {4'd0, stream_data[10:4]};
                        state_d  = S_LEN1;
                    end else begin
                        stream_width = 4'd13;
                        offset_d     = stream_data[10:0];
                        state_d      = (stream_data[10:0] == 11'd0) ? S_ERR : S_LEN1;
                    end
                end else if (eos) begin
                    state_d = S_END;
                end
            end
            S_LEN1: begin
                if (dec_ok) begin
                    stream_ack   = 1'b1;
                    stream_width = 4'd2;
                    if (&stream_data[12:11]) begin
                        state_d = S_LEN2;
                    end else begin
                        len_d   = 16'd2 + {14'd0, stream_data[12:11]};
                        raddr_d = rd_addr;
                        state_d = rd_state;
                    end
                end else if (eos) begin
                    state_d = S_END;
                end
            end
            S_LEN2: begin
                if (dec_ok) begin
                    stream_ack   = 1'b1;
                    stream_width = 4'd2;
                    if (&stream_data[12:11]) begin
                        len_d   = 16'd8;
                        state_d = S_LENX;
                    end else begin
                        len_d   = 16'd5 + {14'd0, stream_data[12:11]};
                        raddr_d = rd_addr;
                        state_d = rd_state;
                    end
                end else if (eos) begin
                    state_d = S_END;
                end
            end
            S_LENX: begin
                if (dec_ok) begin
                    stream_ack   = 1'b1;
                    stream_width = 4'd4;
                    len_d        = len_sum[16] ? 16'hFFFF : len_sum[15:0];
                    if (stream_data[12:9] != 4'hF) begin
                        raddr_d = rd_addr;
                        state_d = rd_state;
                    end
                end else if (eos) begin
                    state_d = S_END;
                end
            end
            S_RD: begin
                out_valid_d = 1'b1;
                state_d     = S_EMIT;
            end
            S_EMIT: begin
                if (accept) begin
                    len_d   = len_q - 1'b1;
                    raddr_d = raddr_q + 1'b1;
                    state_d = (len_q == 16'd1) ? S_TOKEN : S_RD;
                end
            end
            default: ;
        endcase

        if (state_d == S_ERR) out_valid_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            waddr_q     <= '0;
            raddr_q     <= '0;
            len_q       <= '0;
            offset_q    <= '0;
            wrapped_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_done_q  <= 1'b0;
            err_q       <= 1'b0;
            byte_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            waddr_q     <= waddr_d;
            raddr_q     <= raddr_d;
            len_q       <= len_d;
            offset_q    <= offset_d;
            wrapped_q   <= wrapped_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_done_q  <= out_done_d;
            err_q       <= err_d;
            byte_cnt_q  <= byte_cnt_d;
        end
    end

endmodule

// File: tb/tb_lzs_decode_core.sv
// Directed bench for lzs_decode_core: bit-string token streams with hand-decoded
// expected bytes, plus backpressure and mid-copy reset sequences.
module tb_lzs_decode_core;
    localparam int AW = 11;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst, ce, stream_valid, stream_done, out_ready;
    logic [12:0]   stream_data;
    logic [3:0]    stream_width;
    logic          stream_ack, out_valid, out_done, err, hwe;
    logic [7:0]    out_data, hdata_o, hdata;
    logic [CW-1:0] byte_cnt;
    logic [AW-1:0] hwaddr, hraddr;

    always #5 clk = ~clk;

    lzs_decode_core #(.HIST_AW(AW), .CNT_W(CW), .CHK_OFF(1)) dut (
        .clk(clk), .rst(rst), .ce(ce),
        .stream_data(stream_data), .stream_valid(stream_valid), .stream_done(stream_done),
        .stream_width(stream_width), .stream_ack(stream_ack),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_done(out_done), .err(err), .byte_cnt(byte_cnt),
        .hwaddr(hwaddr), .hwe(hwe), .hdata_o(hdata_o), .hraddr(hraddr), .hdata(hdata)
    );

    // history RAM, synchronous read
    logic [7:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (hwe) mem[hwaddr] <= hdata_o;
        hdata <= mem[hraddr];
    end

    typedef struct {
        string name;
        string bits;
        string exp;
        string widths;
        bit    done;
        bit    er;
        int    gap;
    } vec_t;
    vec_t tv[$];

    bit   sq[$];
    bit   en_done;
    byte unsigned got[$];
    int   gaddr[$], gcyc[$], wlog[$];
    int   cyc_n, n_chk, n_fail, inv_bad;
    logic [7:0] smp_data;
    logic smp_valid, smp_hwe, smp_ack;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_s(input string name, input string act, input string exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
        end
    endtask

    task automatic update_stream();
        logic [12:0] d = '0;
        for (int j = 0; j < 13; j++) if (j < sq.size()) d[12-j] = sq[j];
        stream_data  = d;
        stream_valid = (sq.size() > 0);
        stream_done  = en_done && (sq.size() == 0);
    endtask

    task automatic cyc();
        int w;
        bit a;
        @(negedge clk);
        smp_data  = out_data;
        smp_valid = out_valid;
        smp_hwe   = hwe;
        smp_ack   = stream_ack;
        if (hwe !== (out_valid & out_ready)) inv_bad++;
        if (!stream_ack && stream_width !== 4'd0) inv_bad++;
        if (out_valid && out_ready) begin
            got.push_back(out_data);
            gaddr.push_back(int'(hwaddr));
            gcyc.push_back(cyc_n);
        end
        a = stream_ack;
        w = int'(stream_width);
        if (a) wlog.push_back(w);
        @(posedge clk);
        #1;
        if (a) for (int j = 0; j < w && sq.size() > 0; j++) void'(sq.pop_front());
        update_stream();
        cyc_n++;
    endtask

    task automatic clear_logs();
        got.delete(); gaddr.delete(); gcyc.delete(); wlog.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1; ce = 1'b0; out_ready = 1'b1;
        sq.delete(); en_done = 1'b0; update_stream();
        cyc();
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic load(input string s);
        for (int j = 0; j < s.len(); j++) sq.push_back(s[j] == 8'h31);
        en_done = 1'b1;
        update_stream();
    endtask

    task automatic start();
        ce = 1'b1; cyc(); ce = 1'b0;
    endtask

    task automatic run(input int budget, output bit to);
        int k = 0;
        while (!(out_done || err) && k < budget) begin cyc(); k++; end
        to = !(out_done || err);
        repeat (4) cyc();
    endtask

    function automatic string got_str();
        string g = "";
        foreach (got[k]) g = {g, $sformatf("%c", got[k])};
        return g;
    endfunction

    function automatic int addr_errs();
        int e = 0;
        foreach (gaddr[k]) if (gaddr[k] != k) e++;
        return e;
    endfunction

    task automatic add(input string n, input string b, input string e, input string w,
                       input bit d, input bit r, input int g);
        vec_t v;
        v.name = n; v.bits = b; v.exp = e; v.widths = w; v.done = d; v.er = r; v.gap = g;
        tv.push_back(v);
    endtask

    initial begin
        bit    to;
        string ws;
        int    k;
        cyc_n = 0; n_chk = 0; n_fail = 0; inv_bad = 0;

        add("lit_A_end",   {"001000001", "110000000"}, "A", "99", 1, 0, 0);
        add("abab_short",  {"001100001", "001100010", "110000010", "00", "110000000"},
            "abab", "99929", 1, 0, 2);
        add("x_run_26",    {"001111000", "110000001", "11", "11", "1111", "0011", "110000000"},
            {"xxxxxxxxx", "xxxxxxxxx", "xxxxxxxxx"}, "9922449", 1, 0, 2);
        add("m_len2_6",    {"001101101", "110000001", "11", "01", "110000000"},
            "mmmmmmm", "99229", 1, 0, 2);
        add("long_off_3",  {"001100001", "001100010", "001100011", "1000000000011", "01", "110000000"},
            "abcabc", "999d29", 1, 0, 2);
        add("long_off_0",  {"1000000000000", "001111010"}, "", "d", 0, 1, 0);
        add("off5_after3", {"001100001", "001100010", "001100011", "110000101", "00", "001111010"},
            "abc", "99992", 0, 1, 0);
        add("exhausted",   {"001101011"}, "k", "9", 1, 0, 0);

        // reset values, with a valid stream present but no ce
        do_reset();
        load({"001000001", "110000000"});
        cyc();
        check("rst out_valid", smp_valid, 0);
        check("rst stream_ack", smp_ack, 0);
        check("rst hwe", smp_hwe, 0);
        check("rst out_data", smp_data, 0);
        check("rst byte_cnt", byte_cnt, 0);
        check("rst out_done", out_done, 0);
        check("rst err", err, 0);
        check("rst stream_width", stream_width, 0);
        check("rst hwaddr", hwaddr, 0);
        check("rst hraddr", hraddr, 0);

        foreach (tv[i]) begin
            do_reset();
            load(tv[i].bits);
            start();
            run(400, to);
            check({tv[i].name, " timeout"}, to, 0);
            check_s({tv[i].name, " bytes"}, got_str(), tv[i].exp);
            ws = "";
            foreach (wlog[j]) ws = {ws, $sformatf("%h", wlog[j][3:0])};
            check_s({tv[i].name, " widths"}, ws, tv[i].widths);
            check({tv[i].name, " byte_cnt"}, byte_cnt, tv[i].exp.len());
            check({tv[i].name, " out_done"}, out_done, tv[i].done);
            check({tv[i].name, " err"}, err, tv[i].er);
            check({tv[i].name, " hwaddr seq"}, addr_errs(), 0);
            if (tv[i].gap != 0 && gcyc.size() >= 2)
                check({tv[i].name, " copy spacing"}, gcyc[gcyc.size()-1] - gcyc[gcyc.size()-2], tv[i].gap);
        end

        // backpressure during the first copy byte
        do_reset();
        load({"001100001", "001100010", "110000010", "00", "110000000"});
        start();
        k = 0;
        while (got.size() < 2 && k < 50) begin cyc(); k++; end
        check("stall reach literals", got.size(), 2);
        out_ready = 1'b0;
        k = 0;
        while (!out_valid && k < 20) begin cyc(); k++; end
        check("stall reach emit", out_valid, 1);
        for (int s = 0; s < 5; s++) begin
            cyc();
            check("stall out_data", smp_data, 8'h61);
            check("stall hold", {smp_valid, smp_hwe, smp_ack}, 3'b100);
        end
        check("stall no loss", got.size(), 2);
        out_ready = 1'b1;
        run(200, to);
        check("stall timeout", to, 0);
        check_s("stall bytes", got_str(), "abab");
        check("stall byte_cnt", byte_cnt, 4);

        // reset in the middle of a len=10 copy, ce held high throughout
        do_reset();
        load({"001111000", "110000001", "11", "11", "0010", "110000000"});
        ce = 1'b1;
        k = 0;
        while (got.size() < 3 && k < 100) begin cyc(); k++; end
        check("midrst reach copy", got.size(), 3);
        rst = 1'b1;
        cyc();
        rst = 1'b0; ce = 1'b0;
        sq.delete(); en_done = 1'b0; update_stream();
        cyc();
        check("midrst out_valid", smp_valid, 0);
        check("midrst out_data", smp_data, 0);
        check("midrst ack/hwe", {smp_ack, smp_hwe}, 0);
        check("midrst byte_cnt", byte_cnt, 0);
        check("midrst hwaddr", hwaddr, 0);
        check("midrst hraddr", hraddr, 0);
        check("midrst done/err", {out_done, err}, 0);
        check("midrst stream_width", stream_width, 0);
        clear_logs();
        load({"001100001", "001100010", "110000000"});
        start();
        run(200, to);
        check("restart timeout", to, 0);
        check_s("restart bytes", got_str(), "ab");
        check("restart byte_cnt", byte_cnt, 2);
        check("restart hwaddr seq", addr_errs(), 0);

        check("invariants hwe/width", inv_bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end
endmodule
